hello: RTL and testbench

HELLO -- requirements
Module: hello

---
 rtl/hello_pkg.sv | 36 +++
 rtl/hello_bcd_counter.sv | 52 +++++
 rtl/hello.sv | 129 ++++++++++++
 tb/tb_hello.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hello_pkg.sv
// Shared definitions for the hello BCD alarm clock: digit limits, time records
// and the load-value validity check used for both time and alarm loads.
package hello_pkg;

  localparam int SEC_MAX   = 59;
  localparam int MIN_MAX   = 59;
  localparam int HOUR_MAX  = 23;
  localparam int DIGIT_MAX = 9;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } time_t;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } hm_t;

  // True when the digits form a legal 24-hour HH:MM value.
  function automatic logic hm_valid(input logic [1:0] h1, input logic [3:0] h0,
                                    input logic [3:0] m1, input logic [3:0] m0);
    logic hours_ok;
    hours_ok = (h1 < 2'(HOUR_MAX / 10)) ||
               ((h1 == 2'(HOUR_MAX / 10)) && (h0 <= 4'(HOUR_MAX % 10)));
    return hours_ok && (h0 <= 4'(DIGIT_MAX)) &&
           (m1 <= 4'(MIN_MAX / 10)) && (m0 <= 4'(DIGIT_MAX));
  endfunction

endpackage

// File: rtl/hello_bcd_counter.sv
// Two-digit BCD modulo counter (0..MAX) with synchronous load and enable.
// Value updates one cycle after enable/load; o_carry is combinational (enable at MAX).
module hello_bcd_counter #(
  parameter int MAX    = 59,
  parameter int TENS_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_load,
  input  logic [TENS_W-1:0] i_tens,
  input  logic [3:0]        i_units,
  output logic [TENS_W-1:0] o_tens,
  output logic [3:0]        o_units,
  output logic              o_carry
);
  import hello_pkg::*;

  localparam logic [TENS_W-1:0] MAX_TENS  = TENS_W'(MAX / 10);
  localparam logic [3:0]        MAX_UNITS = 4'(MAX % 10);
  localparam logic [3:0]        UNITS_TOP = 4'(DIGIT_MAX);

  logic [TENS_W-1:0] r_tens;
  logic [3:0]        r_units;
  logic              w_at_max;

  assign w_at_max = (r_tens == MAX_TENS) && (r_units == MAX_UNITS);
  assign o_carry  = i_en && w_at_max;
  assign o_tens   = r_tens;
  assign o_units  = r_units;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tens  <= '0;
      r_units <= '0;
    end else if (i_load) begin
      r_tens  <= i_tens;
      r_units <= i_units;
    end else if (i_en) begin
      if (w_at_max) begin
        r_tens  <= '0;
        r_units <= '0;
      end else if (r_units == UNITS_TOP) begin
        r_tens  <= r_tens + TENS_W'(1);
        r_units <= '0;
      end else begin
        r_units <= r_units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/hello.sv
// 24-hour BCD clock HH:MM:SS with one-second prescaler, time/alarm load and alarm flag.
// Loaded time appears one cycle after the load edge; Alarm sets one cycle after a match.
module hello #(
  parameter int CLK_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Hour_in1,
  input  logic [3:0] Hour_in0,
  input  logic [3:0] Minute_in1,
  input  logic [3:0] Minute_in0,
  input  logic       Load_time,
  input  logic       Load_alarm,
  input  logic       Stop_alarm,
  input  logic       Al_On,
  output logic       Alarm,
  output logic [1:0] Hour_out1,
  output logic [3:0] Hour_out0,
  output logic [3:0] Minute_out1,
  output logic [3:0] Minute_out0,
  output logic [3:0] Second_out1,
  output logic [3:0] Second_out0
);
  import hello_pkg::*;

  localparam int              PW      = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0]   TICK_AT = PW'(CLK_PER_SEC - 1);

  logic [PW-1:0] r_presc;
  hm_t           r_alarm_hm;
  logic          r_alarm;

  time_t w_now;
  logic  w_in_valid;
  logic  w_load_time;
  logic  w_load_alarm;
  logic  w_tick;
  logic  w_sec_en;
  logic  w_sec_carry;
  logic  w_min_carry;
  logic  w_day_carry_unused;
  logic  w_alarm_hit;

  assign w_in_valid   = hm_valid(Hour_in1, Hour_in0, Minute_in1, Minute_in0);
  assign w_load_time  = Load_time && w_in_valid;
  assign w_load_alarm = Load_alarm && w_in_valid;

  // A valid time load restarts the second, so the tick is suppressed on that edge.
  assign w_tick   = (r_presc == TICK_AT);
  assign w_sec_en = w_tick && !w_load_time;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_load_time || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  hello_bcd_counter #(.MAX(SEC_MAX), .TENS_W(4)) u_sec (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_sec_en),
    .i_load  (w_load_time),
    .i_tens  (4'd0),
    .i_units (4'd0),
    .o_tens  (w_now.s1),
    .o_units (w_now.s0),
    .o_carry (w_sec_carry)
  );

  hello_bcd_counter #(.MAX(MIN_MAX), .TENS_W(4)) u_min (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_sec_carry),
    .i_load  (w_load_time),
    .i_tens  (Minute_in1),
    .i_units (Minute_in0),
    .o_tens  (w_now.m1),
    .o_units (w_now.m0),
    .o_carry (w_min_carry)
  );

  hello_bcd_counter #(.MAX(HOUR_MAX), .TENS_W(2)) u_hour (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_min_carry),
    .i_load  (w_load_time),
    .i_tens  (Hour_in1),
    .i_units (Hour_in0),
    .o_tens  (w_now.h1),
    .o_units (w_now.h0),
    .o_carry (w_day_carry_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alarm_hm <= '0;
    end else if (w_load_alarm) begin
      r_alarm_hm <= '{h1: Hour_in1, h0: Hour_in0, m1: Minute_in1, m0: Minute_in0};
    end
  end

  // Match only on the :00 second so a stopped alarm stays quiet for the rest of the minute.
  assign w_alarm_hit = (w_now.h1 == r_alarm_hm.h1) && (w_now.h0 == r_alarm_hm.h0) &&
                       (w_now.m1 == r_alarm_hm.m1) && (w_now.m0 == r_alarm_hm.m0) &&
                       (w_now.s1 == 4'd0) && (w_now.s0 == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alarm <= 1'b0;
    end else if (Stop_alarm || !Al_On) begin
      r_alarm <= 1'b0;
    end else if (w_alarm_hit) begin
      r_alarm <= 1'b1;
    end
  end

  assign Alarm       = r_alarm;
  assign Hour_out1   = w_now.h1;
  assign Hour_out0   = w_now.h0;
  assign Minute_out1 = w_now.m1;
  assign Minute_out0 = w_now.m0;
  assign Second_out1 = w_now.s1;
  assign Second_out0 = w_now.s0;

endmodule

// File: tb/tb_hello.sv
// Bench for hello: directed vector table, hand sequences, and random stimulus
// checked every cycle against a seconds-of-day reference model.
module tb_hello;

  logic       clk;
  logic       reset;
  logic [1:0] Hour_in1;
  logic [3:0] Hour_in0, Minute_in1, Minute_in0;
  logic       Load_time, Load_alarm, Stop_alarm, Al_On;

  logic       a_al, b_al;
  logic [1:0] a_h1, b_h1;
  logic [3:0] a_h0, a_m1, a_m0, a_s1, a_s0;
  logic [3:0] b_h0, b_m1, b_m0, b_s1, b_s0;

  hello #(.CLK_PER_SEC(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .Hour_in1(Hour_in1), .Hour_in0(Hour_in0), .Minute_in1(Minute_in1), .Minute_in0(Minute_in0),
    .Load_time(Load_time), .Load_alarm(Load_alarm), .Stop_alarm(Stop_alarm), .Al_On(Al_On),
    .Alarm(a_al), .Hour_out1(a_h1), .Hour_out0(a_h0), .Minute_out1(a_m1), .Minute_out0(a_m0),
    .Second_out1(a_s1), .Second_out0(a_s0)
  );

  hello #(.CLK_PER_SEC(10)) u_dut10 (
    .clk(clk), .reset(reset),
    .Hour_in1(Hour_in1), .Hour_in0(Hour_in0), .Minute_in1(Minute_in1), .Minute_in0(Minute_in0),
    .Load_time(Load_time), .Load_alarm(Load_alarm), .Stop_alarm(Stop_alarm), .Al_On(Al_On),
    .Alarm(b_al), .Hour_out1(b_h1), .Hour_out0(b_h0), .Minute_out1(b_m1), .Minute_out0(b_m0),
    .Second_out1(b_s1), .Second_out0(b_s0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [22:0] a_vec, b_vec;
  assign a_vec = {a_h1, a_h0, a_m1, a_m0, a_s1, a_s0, a_al};
  assign b_vec = {b_h1, b_h0, b_m1, b_m0, b_s1, b_s0, b_al};

  int checks = 0;
  int errors = 0;

  // Reference model: time as seconds of day, alarm as minute of day.
  typedef struct {
    int sod;
    int pre;
    int amin;
    bit al;
  } mdl_t;

  mdl_t md1  = '{0, 0, 0, 1'b0};
  mdl_t md10 = '{0, 0, 0, 1'b0};

  function automatic mdl_t mstep(mdl_t s, int cps);
    mdl_t n = s;
    int hh  = int'(Hour_in1) * 10 + int'(Hour_in0);
    int mm  = int'(Minute_in1) * 10 + int'(Minute_in0);
    bit ok  = (Hour_in0 <= 9) && (Minute_in1 <= 5) && (Minute_in0 <= 9) && (hh <= 23);
    if (reset) begin
      n.sod = 0; n.pre = 0; n.amin = 0; n.al = 1'b0;
      return n;
    end
    if (Stop_alarm || !Al_On) n.al = 1'b0;
    else if ((s.sod % 60 == 0) && (s.sod / 60 == s.amin)) n.al = 1'b1;
    if (Load_time && ok) begin
      n.sod = (hh * 60 + mm) * 60;
      n.pre = 0;
    end else if (s.pre == cps - 1) begin
      n.sod = (s.sod + 1) % 86400;
      n.pre = 0;
    end else begin
      n.pre = s.pre + 1;
    end
    if (Load_alarm && ok) n.amin = hh * 60 + mm;
    return n;
  endfunction

  always @(posedge clk) begin
    md1  = mstep(md1, 1);
    md10 = mstep(md10, 10);
  end

  function automatic logic [22:0] pack(int h, int m, int s, bit al);
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), al};
  endfunction

  function automatic logic [22:0] mexp(mdl_t s);
    return pack(s.sod / 3600, (s.sod / 60) % 60, s.sod % 60, s.al);
  endfunction

  task automatic check(string nm, logic [22:0] act, logic [22:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got hhmmss_al=%h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check("model_cps1", a_vec, mexp(md1));
    check("model_cps10", b_vec, mexp(md10));
  endtask

  task automatic set_in(bit rst, bit lt, bit la, bit stp, bit alon,
                        int h1, int h0, int m1, int m0);
    reset      = rst;
    Load_time  = lt;
    Load_alarm = la;
    Stop_alarm = stp;
    Al_On      = alon;
    Hour_in1   = 2'(h1);
    Hour_in0   = 4'(h0);
    Minute_in1 = 4'(m1);
    Minute_in0 = 4'(m0);
  endtask

  typedef struct {
    bit rst, lt, la, stp, alon;
    int h1, h0, m1, m0;
    int ncyc;
    int eh, em, es;
    bit eal;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl[NV];

  int lh1, lh0, lm1, lm0;

  initial begin
    // rst lt la stp alon | h1 h0 m1 m0 | ncyc | HH MM SS Alarm
    tbl[0]  = '{1,0,0,0,0, 0,0,0,0,   1,  0, 0, 0, 0};
    tbl[1]  = '{0,0,0,0,0, 0,0,0,0,   1,  0, 0, 1, 0};
    tbl[2]  = '{0,1,0,0,0, 2,3,5,8,   1, 23,58, 0, 0};
    tbl[3]  = '{0,0,0,0,0, 0,0,0,0,   3, 23,58, 3, 0};
    tbl[4]  = '{0,0,1,0,1, 2,3,5,9,   1, 23,58, 4, 0};
    tbl[5]  = '{0,0,0,0,1, 0,0,0,0,  56, 23,59, 0, 0};
    tbl[6]  = '{0,0,0,0,1, 0,0,0,0,   1, 23,59, 1, 1};
    tbl[7]  = '{0,0,0,0,1, 0,0,0,0,   2, 23,59, 3, 1};
    tbl[8]  = '{0,0,0,1,1, 0,0,0,0,   1, 23,59, 4, 0};
    tbl[9]  = '{0,0,0,0,1, 0,0,0,0,  55, 23,59,59, 0};
    tbl[10] = '{0,0,0,0,1, 0,0,0,0,   1,  0, 0, 0, 0};
    tbl[11] = '{0,1,0,0,1, 2,3,5,9,   1, 23,59, 0, 0};
    tbl[12] = '{0,0,0,0,1, 0,0,0,0,   1, 23,59, 1, 1};
    tbl[13] = '{0,0,0,0,0, 0,0,0,0,   1, 23,59, 2, 0};
    tbl[14] = '{0,1,0,0,0, 2,4,0,0,   1, 23,59, 3, 0};
    tbl[15] = '{0,1,0,0,0, 1,2,7,10,  1, 23,59, 4, 0};
    tbl[16] = '{0,0,1,0,0, 1,2,0,0,   1, 23,59, 5, 0};
    tbl[17] = '{0,1,0,0,0, 1,1,5,9,   1, 11,59, 0, 0};
    tbl[18] = '{0,0,0,0,0, 0,0,0,0,  61, 12, 0, 1, 0};
    tbl[19] = '{0,1,0,0,1, 1,2,0,0,   1, 12, 0, 0, 0};
    tbl[20] = '{0,0,0,0,1, 0,0,0,0,   1, 12, 0, 1, 1};
    tbl[21] = '{1,1,0,0,1, 0,5,0,0,   1,  0, 0, 0, 0};
    tbl[22] = '{0,0,0,0,1, 0,0,0,0,   1,  0, 0, 1, 1};
    tbl[23] = '{0,0,0,1,1, 0,0,0,0,   1,  0, 0, 2, 0};
    tbl[24] = '{0,1,1,0,1, 1,0,3,0,   1, 10,30, 0, 0};
    tbl[25] = '{0,0,0,0,1, 0,0,0,0,   1, 10,30, 1, 1};
    tbl[26] = '{0,1,0,1,1, 1,0,3,0,   1, 10,30, 0, 0};
    tbl[27] = '{0,0,0,1,1, 0,0,0,0,   1, 10,30, 1, 0};
    tbl[28] = '{0,0,0,0,1, 0,0,0,0,   1, 10,30, 2, 0};

    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      set_in(tbl[i].rst, tbl[i].lt, tbl[i].la, tbl[i].stp, tbl[i].alon,
             tbl[i].h1, tbl[i].h0, tbl[i].m1, tbl[i].m0);
      cyc();
      set_in(0, 0, 0, 0, tbl[i].alon, 0, 0, 0, 0);
      for (int k = 1; k < tbl[i].ncyc; k++) cyc();
      check($sformatf("vec%0d", i), a_vec, pack(tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].eal));
    end

    // Midnight rollover from a loaded 23:59.
    set_in(0, 1, 0, 0, 0, 2, 3, 5, 9);
    cyc();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 59; k++) cyc();
    check("rollover_59", a_vec, pack(23, 59, 59, 0));
    cyc();
    check("rollover_00", a_vec, pack(0, 0, 0, 0));

    // Ten-cycle prescaler, and a load restarting it mid-count.
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    set_in(0, 1, 0, 0, 0, 0, 1, 0, 0);
    cyc();
    check("cps10_load", b_vec, pack(1, 0, 0, 0));
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) cyc();
    check("cps10_hold9", b_vec, pack(1, 0, 0, 0));
    cyc();
    check("cps10_tick10", b_vec, pack(1, 0, 1, 0));
    for (int k = 0; k < 5; k++) cyc();
    set_in(0, 1, 0, 0, 0, 0, 2, 0, 0);
    cyc();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) cyc();
    check("cps10_reload_hold9", b_vec, pack(2, 0, 0, 0));
    cyc();
    check("cps10_reload_tick", b_vec, pack(2, 0, 1, 0));

    // Random stimulus; time loads often reuse the last alarm value so the alarm fires.
    lh1 = 0; lh0 = 0; lm1 = 0; lm0 = 0;
    Al_On = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 299) == 0);
      Load_time  = ($urandom_range(0, 39) == 0);
      Load_alarm = ($urandom_range(0, 29) == 0);
      Stop_alarm = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) Al_On = ~Al_On;
      if (Load_time && $urandom_range(0, 1) == 1) begin
        Hour_in1 = 2'(lh1); Hour_in0 = 4'(lh0);
        Minute_in1 = 4'(lm1); Minute_in0 = 4'(lm0);
      end else begin
        Hour_in1   = 2'($urandom_range(0, 2));
        Hour_in0   = 4'($urandom_range(0, 10));
        Minute_in1 = 4'($urandom_range(0, 6));
        Minute_in0 = 4'($urandom_range(0, 10));
      end
      if (Load_alarm) begin
        lh1 = int'(Hour_in1); lh0 = int'(Hour_in0);
        lm1 = int'(Minute_in1); lm0 = int'(Minute_in0);
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
